// File: rtl/int_sequencer_if.sv
// PIC handshake plus data-memory port of the interrupt sequencer.
// The master side is the sequencer; the slave side is the PIC and memory.
interface int_sequencer_if;
  logic        interrupt;
  logic [15:0] intVect;
  logic        intAck;

  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_w_en;
  logic        mem_r_en;
  logic [7:0]  mem_din;

  modport master (
    input  interrupt, intVect, mem_din,
    output intAck, mem_addr, mem_dout, mem_w_en, mem_r_en
  );

  modport slave (
    output interrupt, intVect, mem_din,
    input  intAck, mem_addr, mem_dout, mem_w_en, mem_r_en
  );
endinterface

// File: rtl/int_sequencer.sv
// CPU-side interrupt entry/return sequencer: pushes PC and flags on entry,
// pops them on reti, and drives the PIC acknowledge and the global enable.
module int_sequencer #(
  parameter int FLAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  int_sequencer_if.master      bus,
  input  logic                 boundary,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 reti,
  input  logic [15:0]          pc_in,
  input  logic [15:0]          sp_in,
  input  logic [FLAG_W-1:0]    flags_in,
  output logic                 busy,
  output logic                 pc_load,
  output logic [15:0]          pc_out,
  output logic                 sp_load,
  output logic [15:0]          sp_out,
  output logic                 flags_load,
  output logic [FLAG_W-1:0]    flags_out,
  output logic                 ie
);

  typedef enum logic [3:0] {
    IDLE,
    PUSH_H,
    PUSH_L,
    PUSH_F,
    VECTOR,
    POP_F,
    POP_L,
    POP_H,
    RET
  } state_e;

  state_e            state_q, state_d;
  logic              ie_q, ie_d;
  logic [15:0]       sp_q, sp_d;
  logic [15:0]       pc_q, pc_d;
  logic [7:0]        fbyte_q, fbyte_d;
  logic [7:0]        pc_l_q, pc_l_d;

  logic              busy_q, busy_d;
  logic              int_ack_q, int_ack_d;
  logic              pc_load_q, pc_load_d;
  logic              sp_load_q, sp_load_d;
  logic              flags_load_q, flags_load_d;
  logic [15:0]       sp_out_q, sp_out_d;
  logic [FLAG_W-1:0] flags_out_q, flags_out_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic              mem_r_en_q, mem_r_en_d;

  // Flag byte saved on entry: ie in bit 7, flags in the low bits.
  logic [7:0] entry_fbyte;

  always_comb begin
    entry_fbyte                = '0;
    entry_fbyte[FLAG_W-1:0]    = flags_in;
    entry_fbyte[7]             = ie_q;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    ie_d         = ie_q;
    sp_d         = sp_q;
    pc_d         = pc_q;
    fbyte_d      = fbyte_q;
    pc_l_d       = pc_l_q;
    int_ack_d    = 1'b0;
    pc_load_d    = 1'b0;
    sp_load_d    = 1'b0;
    flags_load_d = 1'b0;
    sp_out_d     = '0;
    flags_out_d  = '0;
    mem_addr_d   = '0;
    mem_dout_d   = '0;
    mem_w_en_d   = 1'b0;
    mem_r_en_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (boundary) begin
          if (reti) begin
            state_d    = POP_F;
            sp_d       = sp_in;
            mem_r_en_d = 1'b1;
            mem_addr_d = sp_in + 16'd1;
          end else if (bus.interrupt && ie_q) begin
            state_d    = PUSH_H;
            sp_d       = sp_in;
            pc_d       = pc_in;
            fbyte_d    = entry_fbyte;
            mem_w_en_d = 1'b1;
            mem_addr_d = sp_in;
            mem_dout_d = pc_in[15:8];
          end else if (di) begin
            ie_d = 1'b0;
          end else if (ei) begin
            ie_d = 1'b1;
          end
        end
      end

      PUSH_H: begin
        state_d    = PUSH_L;
        mem_w_en_d = 1'b1;
        mem_addr_d = sp_q - 16'd1;
        mem_dout_d = pc_q[7:0];
      end

      PUSH_L: begin
        state_d    = PUSH_F;
        mem_w_en_d = 1'b1;
        mem_addr_d = sp_q - 16'd2;
        mem_dout_d = fbyte_q;
      end

      PUSH_F: begin
        state_d   = VECTOR;
        int_ack_d = 1'b1;
        pc_load_d = 1'b1;
        sp_load_d = 1'b1;
        sp_out_d  = sp_q - 16'd3;
      end

      VECTOR: begin
        state_d = IDLE;
        ie_d    = 1'b0;
      end

      POP_F: begin
        state_d    = POP_L;
        mem_r_en_d = 1'b1;
        mem_addr_d = sp_q + 16'd2;
      end

      POP_L: begin
        state_d    = POP_H;
        mem_r_en_d = 1'b1;
        mem_addr_d = sp_q + 16'd3;
        fbyte_d    = bus.mem_din;
      end

      // ie is restored here so the handler's caller sees it during RET.
      POP_H: begin
        state_d      = RET;
        pc_l_d       = bus.mem_din;
        pc_load_d    = 1'b1;
        flags_load_d = 1'b1;
        sp_load_d    = 1'b1;
        sp_out_d     = sp_q + 16'd3;
        flags_out_d  = fbyte_q[FLAG_W-1:0];
        ie_d         = fbyte_q[7];
      end

      RET: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the saved-context registers are reset along with the control
      // state so a sequence aborted by reset leaves no stale PC or flags.
      state_q      <= IDLE;
      ie_q         <= 1'b0;
      sp_q         <= '0;
      pc_q         <= '0;
      fbyte_q      <= '0;
      pc_l_q       <= '0;
      busy_q       <= 1'b0;
      int_ack_q    <= 1'b0;
      pc_load_q    <= 1'b0;
      sp_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      sp_out_q     <= '0;
      flags_out_q  <= '0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      mem_w_en_q   <= 1'b0;
      mem_r_en_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      ie_q         <= ie_d;
      sp_q         <= sp_d;
      pc_q         <= pc_d;
      fbyte_q      <= fbyte_d;
      pc_l_q       <= pc_l_d;
      busy_q       <= busy_d;
      int_ack_q    <= int_ack_d;
      pc_load_q    <= pc_load_d;
      sp_load_q    <= sp_load_d;
      flags_load_q <= flags_load_d;
      sp_out_q     <= sp_out_d;
      flags_out_q  <= flags_out_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_r_en_q   <= mem_r_en_d;
    end
  end

  // The vector must be the one presented in the ack cycle, and the popped
  // PC high byte arrives in the RET cycle, so pc_out bypasses a register.
  always_comb begin
    pc_out = '0;
    if (pc_load_q) begin
      pc_out = (state_q == VECTOR) ? bus.intVect : {bus.mem_din, pc_l_q};
    end
  end

  assign busy         = busy_q;
  assign pc_load      = pc_load_q;
  assign sp_load      = sp_load_q;
  assign sp_out       = sp_out_q;
  assign flags_load   = flags_load_q;
  assign flags_out    = flags_out_q;
  assign ie           = ie_q;
  assign bus.intAck   = int_ack_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_w_en = mem_w_en_q;
  assign bus.mem_r_en = mem_r_en_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: per-cycle expectation queue built from the entry
// and return rules, directed scenarios, then randomized traffic.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        boundary = 1'b0;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        reti = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] sp_in = '0;
  logic [3:0]  flags_in = '0;

  logic        busy, pc_load, sp_load, flags_load, ie;
  logic [15:0] pc_out, sp_out;
  logic [3:0]  flags_out;

  int_sequencer_if bus ();

  int_sequencer #(.FLAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .boundary  (boundary),
    .ei        (ei),
    .di        (di),
    .reti      (reti),
    .pc_in     (pc_in),
    .sp_in     (sp_in),
    .flags_in  (flags_in),
    .busy      (busy),
    .pc_load   (pc_load),
    .pc_out    (pc_out),
    .sp_load   (sp_load),
    .sp_out    (sp_out),
    .flags_load(flags_load),
    .flags_out (flags_out),
    .ie        (ie)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory: write on the strobed cycle, read data valid the next cycle.
  logic [7:0] mem [0:65535];

  initial begin : memory
    logic        w, r;
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.mem_din = '0;
    forever begin
      @(negedge clk);
      w = bus.mem_w_en;
      r = bus.mem_r_en;
      a = bus.mem_addr;
      d = bus.mem_dout;
      if (w) mem[a] = d;
      @(posedge clk);
      #1;
      bus.mem_din = r ? mem[a] : 8'($urandom);
    end
  end

  // Expected outputs of one busy cycle.
  typedef struct {
    logic        ack, w, r, pcl, spl, fl, vec_pc;
    logic [15:0] addr, pc, sp;
    logic [7:0]  dout;
    logic [3:0]  flags;
    int          ie_set;
  } exp_t;

  function automatic exp_t blank();
    exp_t e;
    e.ack = 0; e.w = 0; e.r = 0; e.pcl = 0; e.spl = 0; e.fl = 0; e.vec_pc = 0;
    e.addr = '0; e.pc = '0; e.sp = '0; e.dout = '0; e.flags = '0;
    e.ie_set = -1;
    return e;
  endfunction

  exp_t        plan[$];
  logic        m_ie = 1'b0;
  logic        chk_on = 1'b0;

  int          ack_count = 0;
  int          ret_count = 0;
  logic [15:0] last_vec_pc, last_vec_sp, last_ret_pc, last_ret_sp;
  logic [3:0]  last_ret_flags;
  logic        last_ret_ie;

  always @(negedge clk) begin : model
    exp_t        e;
    logic        was_idle;
    logic [15:0] s, a1, a2, a3;
    logic [7:0]  fb;
    if (chk_on) begin
      was_idle = (plan.size() == 0);
      e = was_idle ? blank() : plan.pop_front();

      check("busy", busy, !was_idle);
      check("intAck", bus.intAck, e.ack);
      check("mem_w_en", bus.mem_w_en, e.w);
      check("mem_r_en", bus.mem_r_en, e.r);
      if (e.w || e.r) check("mem_addr", bus.mem_addr, e.addr);
      if (e.w) check("mem_dout", bus.mem_dout, e.dout);
      check("pc_load", pc_load, e.pcl);
      if (e.pcl) check("pc_out", pc_out, e.vec_pc ? bus.intVect : e.pc);
      check("sp_load", sp_load, e.spl);
      if (e.spl) check("sp_out", sp_out, e.sp);
      check("flags_load", flags_load, e.fl);
      if (e.fl) check("flags_out", flags_out, e.flags);
      check("ie", ie, m_ie);

      if (bus.intAck) begin
        ack_count++;
        last_vec_pc = pc_out;
        last_vec_sp = sp_out;
      end
      if (flags_load) begin
        ret_count++;
        last_ret_pc    = pc_out;
        last_ret_sp    = sp_out;
        last_ret_flags = flags_out;
        last_ret_ie    = ie;
      end

      if (reset) begin
        plan.delete();
        m_ie = 1'b0;
      end else begin
        if (e.ie_set >= 0) m_ie = e.ie_set[0];
        if (was_idle && boundary) begin
          s = sp_in;
          if (reti) begin
            a1 = s + 16'd1; a2 = s + 16'd2; a3 = s + 16'd3;
            fb = mem[a1];
            e = blank(); e.r = 1; e.addr = a1; plan.push_back(e);
            e.addr = a2; plan.push_back(e);
            e.addr = a3; e.ie_set = int'(fb[7]); plan.push_back(e);
            e = blank(); e.pcl = 1; e.pc = {mem[a3], mem[a2]};
            e.fl = 1; e.flags = fb[3:0]; e.spl = 1; e.sp = a3;
            plan.push_back(e);
          end else if (bus.interrupt && m_ie) begin
            e = blank(); e.w = 1; e.addr = s; e.dout = pc_in[15:8]; plan.push_back(e);
            e.addr = s - 16'd1; e.dout = pc_in[7:0]; plan.push_back(e);
            e.addr = s - 16'd2; e.dout = {m_ie, 3'b000, flags_in}; plan.push_back(e);
            e = blank(); e.ack = 1; e.pcl = 1; e.vec_pc = 1; e.spl = 1;
            e.sp = s - 16'd3; e.ie_set = 0;
            plan.push_back(e);
          end else if (di) begin
            m_ie = 1'b0;
          end else if (ei) begin
            m_ie = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bus.interrupt = 1'b0;
    bus.intVect   = '0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst intAck", bus.intAck, 0);
    check("rst mem_w_en", bus.mem_w_en, 0);
    check("rst mem_r_en", bus.mem_r_en, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_dout", bus.mem_dout, 0);
    check("rst loads", {pc_load, sp_load, flags_load}, 0);
    check("rst pc_out", pc_out, 0);
    check("rst sp_out", sp_out, 0);
    check("rst flags_out", flags_out, 0);
    check("rst ie", ie, 0);
    step();
    reset  = 1'b0;
    chk_on = 1'b1;

    // Basic entry
    step(); boundary = 1; ei = 1;
    step(); ei = 0; bus.interrupt = 1; bus.intVect = 16'h1234;
    pc_in = 16'h0200; sp_in = 16'h00FF; flags_in = 4'h5;
    step(); boundary = 0;
    repeat (5) step();
    bus.interrupt = 0;
    @(negedge clk);
    check("entry wr pc_h", mem[16'h00FF], 8'h02);
    check("entry wr pc_l", mem[16'h00FE], 8'h00);
    check("entry wr flags", mem[16'h00FD], 8'h85);
    check("entry vec pc", last_vec_pc, 16'h1234);
    check("entry vec sp", last_vec_sp, 16'h00FC);
    check("entry ack count", ack_count, 1);
    check("entry ie after", ie, 0);
    check("entry busy after", busy, 0);

    // Return
    step(); boundary = 1; reti = 1; sp_in = 16'h00FC;
    step(); boundary = 0; reti = 0;
    repeat (5) step();
    @(negedge clk);
    check("ret pc", last_ret_pc, 16'h0200);
    check("ret flags", last_ret_flags, 4'h5);
    check("ret sp", last_ret_sp, 16'h00FF);
    check("ret ie", last_ret_ie, 1);
    check("ret count", ret_count, 1);
    check("ret no ack", ack_count, 1);

    // Masked by ie=0, then by boundary=0
    step(); boundary = 1; di = 1;
    step(); di = 0; bus.interrupt = 1;
    repeat (20) step();
    boundary = 1; bus.interrupt = 0; ei = 1;
    step(); ei = 0; boundary = 0; bus.interrupt = 1;
    repeat (20) step();
    bus.interrupt = 0;
    @(negedge clk);
    check("masked ack count", ack_count, 1);

    // Preempting vector during PUSH_L
    step(); boundary = 1; bus.interrupt = 1; bus.intVect = 16'h1111;
    pc_in = 16'hABCD; sp_in = 16'h4000; flags_in = 4'hA;
    step(); boundary = 0;
    step(); bus.intVect = 16'h2222;
    repeat (4) step();
    bus.interrupt = 0;
    @(negedge clk);
    check("preempt vec pc", last_vec_pc, 16'h2222);
    check("preempt ack count", ack_count, 2);

    // SP wrap-around on entry
    step(); boundary = 1; ei = 1;
    step(); ei = 0; bus.interrupt = 1; bus.intVect = 16'h0BAD;
    pc_in = 16'h3456; sp_in = 16'h0001; flags_in = 4'h3;
    step(); boundary = 0;
    repeat (5) step();
    bus.interrupt = 0;
    @(negedge clk);
    check("wrap wr 0001", mem[16'h0001], 8'h34);
    check("wrap wr 0000", mem[16'h0000], 8'h56);
    check("wrap wr FFFF", mem[16'hFFFF], 8'h83);
    check("wrap vec sp", last_vec_sp, 16'hFFFE);
    check("wrap ack count", ack_count, 3);

    // Reset during PUSH_L
    mem[16'h1FFE] = 8'h5A;
    step(); boundary = 1; ei = 1;
    step(); ei = 0; bus.interrupt = 1; bus.intVect = 16'h0777;
    pc_in = 16'h1357; sp_in = 16'h2000; flags_in = 4'h9;
    step(); boundary = 0;
    step(); reset = 1;
    step(); reset = 0; bus.interrupt = 0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort ie", ie, 0);
    repeat (6) step();
    @(negedge clk);
    check("abort ack count", ack_count, 3);
    check("abort no flag write", mem[16'h1FFE], 8'h5A);

    // ei and di together
    step(); boundary = 1; ei = 1;
    step(); ei = 1; di = 1;
    step(); ei = 0; di = 0; boundary = 0;
    @(negedge clk);
    check("ei+di ie", ie, 0);

    // reti beats interrupt
    step(); boundary = 1; ei = 1;
    step(); ei = 0; reti = 1; bus.interrupt = 1; sp_in = 16'h00FC;
    step(); reti = 0; boundary = 0;
    repeat (5) step();
    bus.interrupt = 0;
    @(negedge clk);
    check("reti prio ret count", ret_count, 2);
    check("reti prio ack count", ack_count, 3);
    check("reti prio pc", last_ret_pc, 16'h0200);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      boundary      = ($urandom_range(0, 3) != 0);
      bus.interrupt = ($urandom_range(0, 2) == 0);
      bus.intVect   = 16'($urandom);
      ei            = ($urandom_range(0, 6) == 0);
      di            = ($urandom_range(0, 9) == 0);
      reti          = ($urandom_range(0, 11) == 0);
      pc_in         = 16'($urandom);
      flags_in      = 4'($urandom);
      case ($urandom_range(0, 7))
        0:       sp_in = 16'h0000;
        1:       sp_in = 16'h0001;
        2:       sp_in = 16'hFFFF;
        3:       sp_in = 16'hFFFD;
        default: sp_in = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 199) == 0);
    end
    step();
    reset = 0; boundary = 0; ei = 0; di = 0; reti = 0; bus.interrupt = 0;
    repeat (8) step();
    @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
